jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

Parametrised IEEE 1149.1-style TAP controller: the 16-state TMS-driven FSM plus a real instruction register and selectable data registers (BYPASS, IDCODE, USER). Adds capture/shift/update semantics, serial TDO with an output enable, and a parallel user-register interface. Sits between the external JTAG pins (with `clk` as TCK) and on-chip debug or configuration logic.

## Interface
- `IR_WIDTH`, default 4: instruction register width (≥2).
- `DR_WIDTH`, default 8: USER data register width (≥1).
- `IDCODE_VAL`, default 32'h1234_5001: IDCODE register value; bit 0 must be 1.
- `clk`  in  1  TCK; the TAP clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tms`  in  1  test mode select, sampled on the rising edge.
- `tdi`  in  1  serial data in, sampled on the rising edge.
- `tdo`  out  1  serial data out, changes on the falling edge.
- `tdo_en`  out  1  high while the registered state is SHIFT_DR or SHIFT_IR.
- `state`  out  4  current TAP state.
- `ir`  out  IR_WIDTH  active (updated) instruction.
- `user_din`  in  DR_WIDTH  parallel value captured in CAPTURE_DR when USER is selected.
- `user_dout`  out  DR_WIDTH  parallel value loaded in UPDATE_DR when USER is selected.
- `user_update`  out  1  one-cycle pulse when `user_dout` is loaded.

## Operation
- State encoding (0–15): TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- Transitions follow the standard 1149.1 graph. Five consecutive `tms`=1 edges reach TLR from any state. Illegal encodings go to TLR.
- Opcodes: IDCODE = 1, USER = 2, BYPASS = all ones. Any other opcode selects BYPASS.
- DR selection is decoded from `ir`. Lengths: BYPASS 1, IDCODE 32, USER DR_WIDTH.
- Actions on the rising edge, keyed on the current state:
  - CAP_IR: IR shift register ← {0…0,01}.
  - SH_IR: shift right, `tdi` enters the MSB.
  - UPD_IR: `ir` ← IR shift register.
  - CAP_DR: selected DR ← BYPASS 0 / IDCODE_VAL / `user_din`.
  - SH_DR: selected DR shifts right, `tdi` enters the MSB.
  - UPD_DR with USER selected: `user_dout` ← USER shift register, and `user_update` is high for that single cycle.
- In TLR, `ir` ← IDCODE on every edge. Shift registers hold their values in every state other than the ones above.
- Shifting is LSB first.

## Timing
- Reset values: `state` = TLR, `ir` = 1, `tdo` = 0, `tdo_en` = 0, `user_dout` = 0, `user_update` = 0, all shift registers 0.
- Falling edge of `clk`:
  - In SH_DR or SH_IR: `tdo` ← LSB of the active shift register and `tdo_en` ← 1.
  - Otherwise: `tdo` ← 0 and `tdo_en` ← 0.
- The first bit on `tdo` is the captured LSB, valid half a cycle after entering the shift state.
- A rising edge with `tms`=1 in a shift state still performs the shift (the last bit), then moves to EX1.
- PAUSE and EXIT states hold the shift registers. EX2→SHIFT resumes shifting without recapture.
- BYPASS adds exactly 1 cycle of delay from `tdi` to `tdo`.
- `reset` asserted mid-shift forces all reset values immediately. `user_dout` is not updated by the partial shift.
- `ir` and `user_dout` change only in their UPD states, so outputs never glitch during a shift.

## Structure
- Package `jtag_pkg` holds:
  - the 4-bit state enum/constants;
  - the opcode constants IDCODE, USER and BYPASS (parametrised on IR_WIDTH).
- Sub-module `jtag_tap_fsm` contains the state register and next-state logic (inputs `clk`, `reset`, `tms`; output `state`).
- The top level contains the IR, the DR shift registers, the DR mux and the negedge TDO stage.

## Test plan
- Reset and TMS reset:
  - assert `reset` → `state`=0, `ir`=4'b0001, `tdo_en`=0;
  - from SH_DR, drive 5× `tms`=1 → `state`=0.
- IDCODE read: from TLR, drive `tms` 0,1,0,0, then 32 shift cycles (`tms`=1 on the last) → `tdo` serialises 32'h1234_5001 LSB first and `tdo_en` is high for exactly 32 cycles.
- IR capture/load: shift in 4'b0010 → the first 4 `tdo` bits read 1,0,0,0; after UPD_IR, `ir`=2.
- USER DR with `user_din`=8'hA5: shift in 8'h3C, then go to UPD_DR → `tdo` serialises A5, `user_dout`=8'h3C, and `user_update` pulses for exactly 1 cycle.
- BYPASS: `ir`=4'hF, shift `tdi` 1,0,1,1 → `tdo` reads 0,1,0,1,1 (one cycle delay); `ir`=4'h7 behaves identically.
- Pause/resume and async reset:
  - USER shift of 4 bits, then PAU_DR for 3 cycles, EX2→SH_DR, then 4 more bits → `user_dout` equals the 8 bits shifted;
  - a second run with `reset` pulsed mid-shift → `user_dout`=0 and `state`=0.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: TAP state encoding,
// instruction opcodes and the data-register selector type.
package jtag_pkg;

  // TAP states, numbered in the conventional 1149.1 order.
  localparam logic [3:0] ST_TLR    = 4'd0;
  localparam logic [3:0] ST_RTI    = 4'd1;
  localparam logic [3:0] ST_SEL_DR = 4'd2;
  localparam logic [3:0] ST_CAP_DR = 4'd3;
  localparam logic [3:0] ST_SH_DR  = 4'd4;
  localparam logic [3:0] ST_EX1_DR = 4'd5;
  localparam logic [3:0] ST_PAU_DR = 4'd6;
  localparam logic [3:0] ST_EX2_DR = 4'd7;
  localparam logic [3:0] ST_UPD_DR = 4'd8;
  localparam logic [3:0] ST_SEL_IR = 4'd9;
  localparam logic [3:0] ST_CAP_IR = 4'd10;
  localparam logic [3:0] ST_SH_IR  = 4'd11;
  localparam logic [3:0] ST_EX1_IR = 4'd12;
  localparam logic [3:0] ST_PAU_IR = 4'd13;
  localparam logic [3:0] ST_EX2_IR = 4'd14;
  localparam logic [3:0] ST_UPD_IR = 4'd15;

  // Opcode values; callers size them to their IR width.
  localparam int unsigned OPC_IDCODE = 1;
  localparam int unsigned OPC_USER   = 2;

  // BYPASS is all ones at whatever IR width is in use (IR width <= 32).
  function automatic logic [31:0] opc_bypass(input int unsigned width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

  // Which data register sits between tdi and tdo.
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state machine, advanced by tms on each TCK rise.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tms,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Standard 1149.1 transition graph; every encoding is covered, default is a safe fallback.
  always_comb begin
    state_d = ST_TLR;
    case (state_q)
      ST_TLR:    state_d = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = tms ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = tms ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = tms ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = tms ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = tms ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  // State register, forced to Test-Logic-Reset asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_TLR;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP: instruction register, BYPASS/IDCODE/USER data registers,
// capture/shift/update handling and the falling-edge TDO stage.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned DR_WIDTH   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] ir,
  input  logic [DR_WIDTH-1:0] user_din,
  output logic [DR_WIDTH-1:0] user_dout,
  output logic                user_update
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(OPC_USER);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(opc_bypass(IR_WIDTH));

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                byp_q, byp_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [DR_WIDTH-1:0] usr_sr_q, usr_sr_d;
  logic [DR_WIDTH-1:0] user_dout_q, user_dout_d;
  logic                user_update_q, user_update_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  dr_sel_e             dr_sel;

  jtag_tap_fsm u_fsm (
    .clk   (clk),
    .reset (reset),
    .tms   (tms),
    .state (state)
  );

  // Decode the active instruction; unknown opcodes fall back to BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == OP_IDCODE)      dr_sel = DR_IDCODE;
    else if (ir_q == OP_USER)   dr_sel = DR_USER;
    else if (ir_q == OP_BYPASS) dr_sel = DR_BYPASS;
  end

  // Capture/shift/update actions keyed on the current TAP state; all else holds.
  always_comb begin
    ir_sr_d       = ir_sr_q;
    ir_d          = ir_q;
    byp_d         = byp_q;
    id_sr_d       = id_sr_q;
    usr_sr_d      = usr_sr_q;
    user_dout_d   = user_dout_q;
    user_update_d = 1'b0;
    case (state)
      ST_TLR:    ir_d = OP_IDCODE;
      ST_CAP_IR: ir_sr_d = IR_WIDTH'(1);
      ST_SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      ST_UPD_IR: ir_d = ir_sr_q;
      ST_CAP_DR: begin
        case (dr_sel)
          DR_IDCODE: id_sr_d  = IDCODE_VAL;
          DR_USER:   usr_sr_d = user_din;
          default:   byp_d    = 1'b0;
        endcase
      end
      ST_SH_DR: begin
        case (dr_sel)
          DR_IDCODE: id_sr_d  = {tdi, id_sr_q[31:1]};
          // Widened shift keeps this legal for a 1-bit USER register.
          DR_USER:   usr_sr_d = DR_WIDTH'({tdi, usr_sr_q} >> 1);
          default:   byp_d    = tdi;
        endcase
      end
      ST_UPD_DR: begin
        if (dr_sel == DR_USER) begin
          user_dout_d   = usr_sr_q;
          user_update_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Rising-edge register bank for IR, data registers and the user interface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_sr_q       <= '0;
      ir_q          <= OP_IDCODE;
      byp_q         <= 1'b0;
      id_sr_q       <= '0;
      usr_sr_q      <= '0;
      user_dout_q   <= '0;
      user_update_q <= 1'b0;
    end else begin
      ir_sr_q       <= ir_sr_d;
      ir_q          <= ir_d;
      byp_q         <= byp_d;
      id_sr_q       <= id_sr_d;
      usr_sr_q      <= usr_sr_d;
      user_dout_q   <= user_dout_d;
      user_update_q <= user_update_d;
    end
  end

  // Select the LSB of whichever register is shifting; drive zero when idle.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state == ST_SH_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (state == ST_SH_DR) begin
      tdo_en_d = 1'b1;
      case (dr_sel)
        DR_IDCODE: tdo_d = id_sr_q[0];
        DR_USER:   tdo_d = usr_sr_q[0];
        default:   tdo_d = byp_q;
      endcase
    end
  end

  // TDO launches on the falling edge so it is stable at the next rising edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo         = tdo_q;
  assign tdo_en      = tdo_en_q;
  assign ir          = ir_q;
  assign user_dout   = user_dout_q;
  assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: table-driven state walk, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_jtag_tap_ctrl;

  localparam int IRW = 4;
  localparam int DRW = 8;
  localparam logic [31:0] IDV = 32'h1234_5001;

  logic           clk = 1'b0;
  logic           reset;
  logic           tms, tdi;
  logic           tdo, tdo_en;
  logic [3:0]     state;
  logic [IRW-1:0] ir;
  logic [DRW-1:0] user_din, user_dout;
  logic           user_update;

  int errors = 0;
  int checks = 0;

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .IDCODE_VAL(IDV)) dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .state(state), .ir(ir), .user_din(user_din), .user_dout(user_dout),
    .user_update(user_update)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural reference model ----------------
  // Next-state table: nxt[state][tms], from the 1149.1 state diagram.
  int nxt [16][2] = '{
    '{1, 0},  '{1, 2},  '{3, 9},  '{4, 5},
    '{4, 5},  '{6, 8},  '{6, 7},  '{4, 8},
    '{1, 2},  '{10, 0}, '{11, 12}, '{11, 12},
    '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
  };

  int             m_state;
  logic [IRW-1:0] m_ir, m_irsr;
  logic           m_byp;
  logic [31:0]    m_id;
  logic [DRW-1:0] m_usr, m_udout;
  logic           m_uupd, m_tdo, m_en;
  logic           last_tdo, last_en;

  // 0 = bypass, 1 = idcode, 2 = user
  function automatic int sel_of(input logic [IRW-1:0] v);
    if (v == 1) return 1;
    if (v == 2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ir = 1; m_irsr = 0; m_byp = 0; m_id = 0; m_usr = 0;
    m_udout = 0; m_uupd = 0; m_tdo = 0; m_en = 0;
  endtask

  task automatic model_rise(input logic t, input logic d, input logic [DRW-1:0] din);
    int s;
    int sel;
    s   = m_state;
    sel = sel_of(m_ir);
    m_uupd = 0;
    if (s == 0)  m_ir = 1;
    if (s == 10) m_irsr = 1;
    if (s == 11) m_irsr = (m_irsr >> 1) | (IRW'(d) << (IRW - 1));
    if (s == 15) m_ir = m_irsr;
    if (s == 3) begin
      if (sel == 1) m_id = IDV;
      else if (sel == 2) m_usr = din;
      else m_byp = 0;
    end
    if (s == 4) begin
      if (sel == 1) m_id = (m_id >> 1) | (32'(d) << 31);
      else if (sel == 2) m_usr = (m_usr >> 1) | (DRW'(d) << (DRW - 1));
      else m_byp = d;
    end
    if (s == 8 && sel == 2) begin
      m_udout = m_usr;
      m_uupd  = 1;
    end
    m_state = nxt[s][t];
  endtask

  task automatic model_fall();
    m_tdo = 0; m_en = 0;
    if (m_state == 11) begin
      m_tdo = m_irsr[0]; m_en = 1;
    end else if (m_state == 4) begin
      m_en = 1;
      case (sel_of(m_ir))
        1:       m_tdo = m_id[0];
        2:       m_tdo = m_usr[0];
        default: m_tdo = m_byp;
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One TCK cycle: inputs applied after a falling edge, outputs checked 1 time unit
  // after each edge.
  task automatic tick(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge clk);
    model_rise(t, d, user_din);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("user_dout", 32'(user_dout), 32'(m_udout));
    chk("user_update", 32'(user_update), 32'(m_uupd));
    @(negedge clk);
    model_fall();
    #1;
    chk("tdo", 32'(tdo), 32'(m_tdo));
    chk("tdo_en", 32'(tdo_en), 32'(m_en));
    last_tdo = tdo;
    last_en  = tdo_en;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir", 32'(ir), 32'h1);
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_user_dout", 32'(user_dout), 32'd0);
    chk("rst_user_update", 32'(user_update), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_state_held", 32'(state), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    last_tdo = tdo;
    last_en  = tdo_en;
  endtask

  // From RTI to SH_DR.
  task automatic goto_shdr();
    tick(1, 0); tick(0, 0); tick(0, 0);
  endtask

  // Shift n bits while in a shift state (tms=1 on the last). dout collects the
  // n bits seen on tdo, starting with the one already presented.
  task automatic shift_seq(input int n, input logic [31:0] din,
                           output logic [31:0] dout, output int en_cnt);
    dout = '0;
    dout[0] = last_tdo;
    en_cnt = last_en ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      if (last_en) en_cnt++;
      if (i < n - 1) dout[i+1] = last_tdo;
    end
  endtask

  // From RTI: load an instruction and return to RTI; cap returns the captured bits.
  task automatic load_ir(input logic [IRW-1:0] v, output logic [31:0] cap);
    int en;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift_seq(IRW, 32'(v), cap, en);
    tick(1, 0); tick(0, 0);
  endtask

  // ---------------- table of TAP walk vectors ----------------
  typedef struct {
    logic       tms;
    logic [3:0] exp_state;
    logic       exp_en;
  } vec_t;

  vec_t walk [22];

  initial begin
    logic [31:0] cap;
    logic [31:0] bits;
    logic [4:0]  byp_bits;
    logic [IRW-1:0] byp_ops [2];
    int en_cnt;
    int pulses;

    walk = '{
      '{0, 4'd1, 0},  '{1, 4'd2, 0},  '{0, 4'd3, 0},  '{0, 4'd4, 1},
      '{1, 4'd5, 0},  '{0, 4'd6, 0},  '{1, 4'd7, 0},  '{0, 4'd4, 1},
      '{1, 4'd5, 0},  '{1, 4'd8, 0},  '{1, 4'd2, 0},  '{1, 4'd9, 0},
      '{0, 4'd10, 0}, '{0, 4'd11, 1}, '{1, 4'd12, 0}, '{0, 4'd13, 0},
      '{1, 4'd14, 0}, '{1, 4'd15, 0}, '{0, 4'd1, 0},  '{1, 4'd2, 0},
      '{1, 4'd9, 0},  '{1, 4'd0, 0}
    };

    tms = 1; tdi = 0; user_din = 8'hA5; reset = 1;
    model_reset();
    #2;
    do_reset();

    // Table-driven walk through all 16 states.
    for (int i = 0; i < 22; i++) begin
      tick(walk[i].tms, 1'b0);
      chk($sformatf("walk%0d_state", i), 32'(state), 32'(walk[i].exp_state));
      chk($sformatf("walk%0d_tdo_en", i), 32'(tdo_en), 32'(walk[i].exp_en));
    end
    $display("walk: %0d vectors applied", 22);

    // IDCODE read from TLR.
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift_seq(32, 32'h0, bits, en_cnt);
    chk("idcode_bits", bits, 32'h1234_5001);
    chk("idcode_en_cycles", 32'(en_cnt), 32'd32);
    tick(1, 0); tick(0, 0);
    $display("idcode: read %h, tdo_en cycles %0d", bits, en_cnt);

    // IR capture/load of USER.
    load_ir(4'b0010, cap);
    chk("ir_capture", cap & 32'hF, 32'h1);
    chk("ir_loaded", 32'(ir), 32'h2);
    $display("ir load: captured %b, ir=%h", cap[3:0], ir);

    // USER DR: capture A5, shift in 3C, update.
    goto_shdr();
    shift_seq(8, 32'h3C, bits, en_cnt);
    chk("user_capture", bits & 32'hFF, 32'hA5);
    pulses = 0;
    tick(1, 0); if (user_update) pulses++;
    tick(0, 0); if (user_update) pulses++;
    chk("user_dout_3c", 32'(user_dout), 32'h3C);
    tick(0, 0); if (user_update) pulses++;
    tick(0, 0); if (user_update) pulses++;
    chk("user_update_pulses", 32'(pulses), 32'd1);
    $display("user dr: captured %h, user_dout=%h, pulses=%0d", bits[7:0], user_dout, pulses);

    // BYPASS with the true opcode and with an unassigned one.
    byp_ops[0] = 4'hF;
    byp_ops[1] = 4'h7;
    for (int k = 0; k < 2; k++) begin
      load_ir(byp_ops[k], cap);
      goto_shdr();
      byp_bits[0] = last_tdo;
      tick(0, 1); byp_bits[1] = last_tdo;
      tick(0, 0); byp_bits[2] = last_tdo;
      tick(0, 1); byp_bits[3] = last_tdo;
      tick(0, 1); byp_bits[4] = last_tdo;
      chk($sformatf("bypass_%h_tdo", byp_ops[k]), 32'(byp_bits), 32'b11010);
      tick(1, 0); tick(1, 0); tick(0, 0);
      $display("bypass ir=%h: tdo seq (first..last) %b", byp_ops[k], {<<{byp_bits}});
    end

    // Pause/resume: 4 bits, PAU_DR 3 cycles, EX2 -> SH_DR, 4 more bits.
    load_ir(4'b0010, cap);
    goto_shdr();
    shift_seq(4, 32'h6, bits, en_cnt);
    tick(0, 0); tick(0, 0); tick(0, 0);
    tick(1, 0); tick(0, 0);
    shift_seq(4, 32'h9, bits, en_cnt);
    tick(1, 0); tick(0, 0);
    chk("pause_resume_dout", 32'(user_dout), 32'h96);
    $display("pause/resume: user_dout=%h", user_dout);

    // TMS reset from SH_DR.
    goto_shdr();
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tms_reset_state", 32'(state), 32'd0);
    $display("tms reset: state=%0d", state);

    // Asynchronous reset in the middle of a USER shift.
    tick(0, 0);
    load_ir(4'b0010, cap);
    goto_shdr();
    tick(0, 1); tick(0, 0); tick(0, 1);
    do_reset();
    chk("midshift_user_dout", 32'(user_dout), 32'd0);
    $display("mid-shift reset: state=%0d user_dout=%h", state, user_dout);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) user_din = DRW'($urandom);
      tick($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)));
    end
    $display("random: 3000 cycles applied");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
